axi_rd_arbiter: RTL and testbench

- Shares the single AXI-style read bus to memory between the instruction cache (master 0) and the data cache (master 1).
- Sits between the two cache miss engines and the memory/crossbar read port.
- Grants one master at a time and locks the grant for a whole burst: AR handshake through the last R beat.
- Checks each burst's beat count against the granted arlen and flags mismatches.

---
 rtl/axi_rd_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master read-bus arbiter: the instruction cache (m0) and the data cache
// (m1) share one AXI-style read port. Ownership is held for a whole burst,
// from the AR handshake through the last R beat. Each burst's beat count is
// checked against the arlen that was granted.
module axi_rd_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int PRIO_MODE = 0     // 0: m1 always wins a tie, 1: round-robin
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] araddr_m0,
    input  logic              arvalid_m0,
    input  logic [1:0]        arburst_m0,
    input  logic [7:0]        arlen_m0,
    input  logic [2:0]        arsize_m0,
    input  logic              rready_m0,
    output logic              arready_m0,
    output logic              rvalid_m0,
    output logic              rlast_m0,
    output logic [DATA_W-1:0] rdata_m0,
    output logic [1:0]        rresp_m0,

    input  logic [ADDR_W-1:0] araddr_m1,
    input  logic              arvalid_m1,
    input  logic [1:0]        arburst_m1,
    input  logic [7:0]        arlen_m1,
    input  logic [2:0]        arsize_m1,
    input  logic              rready_m1,
    output logic              arready_m1,
    output logic              rvalid_m1,
    output logic              rlast_m1,
    output logic [DATA_W-1:0] rdata_m1,
    output logic [1:0]        rresp_m1,

    output logic [ADDR_W-1:0] araddr_s,
    output logic              arvalid_s,
    output logic [1:0]        arburst_s,
    output logic [7:0]        arlen_s,
    output logic [2:0]        arsize_s,
    output logic              rready_s,
    input  logic              arready_s,
    input  logic              rvalid_s,
    input  logic              rlast_s,
    input  logic [DATA_W-1:0] rdata_s,
    input  logic [1:0]        rresp_s,

    output logic [1:0]        grant,
    output logic              burst_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] beat_q,  beat_d;    // beats already accepted in this burst
    logic [7:0] len_q,   len_d;     // arlen captured at the AR handshake
    logic       rr_q,    rr_d;      // last winner: 0 = m0, 1 = m1
    logic       err_q,   err_d;

    // Signals of whichever master currently owns the bus.
    logic              sel_m1;
    logic              sel_arvalid;
    logic              sel_rready;
    logic [ADDR_W-1:0] sel_araddr;
    logic [1:0]        sel_arburst;
    logic [7:0]        sel_arlen;
    logic [2:0]        sel_arsize;

    assign sel_m1      = grant_q[1];
    assign sel_arvalid = sel_m1 ? arvalid_m1 : arvalid_m0;
    assign sel_rready  = sel_m1 ? rready_m1  : rready_m0;
    assign sel_araddr  = sel_m1 ? araddr_m1  : araddr_m0;
    assign sel_arburst = sel_m1 ? arburst_m1 : arburst_m0;
    assign sel_arlen   = sel_m1 ? arlen_m1   : arlen_m0;
    assign sel_arsize  = sel_m1 ? arsize_m1  : arsize_m0;

    logic ar_hs;
    logic r_beat;

    assign ar_hs  = (state_q == AR) && sel_arvalid && arready_s;
    assign r_beat = (state_q == R)  && rvalid_s    && sel_rready;

    // State register plus grant, beat counter, length, rr pointer and error pulse.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            beat_q  <= 8'd0;
            len_q   <= 8'd0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Next state: arbitrate in IDLE, wait for the address handshake, count beats.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        len_d   = len_q;
        rr_d    = rr_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arvalid_m0 || arvalid_m1) begin
                    state_d = AR;
                    if (arvalid_m0 && arvalid_m1) begin
                        if (PRIO_MODE == 0) begin
                            grant_d = 2'b10;
                        end else begin
                            grant_d = rr_q ? 2'b01 : 2'b10;
                        end
                    end else begin
                        grant_d = {arvalid_m1, arvalid_m0};
                    end
                end
            end

            AR: begin
                // A master dropping arvalid here just leaves us waiting.
                if (ar_hs) begin
                    len_d   = sel_arlen;
                    beat_d  = 8'd0;
                    state_d = R;
                end
            end

            R: begin
                if (r_beat) begin
                    beat_d = beat_q + 8'd1;
                    if (rlast_s) begin
                        err_d   = (beat_q != len_q);
                        rr_d    = sel_m1;
                        grant_d = 2'b00;
                        state_d = IDLE;
                    end else begin
                        // Expected final beat arrived without rlast; keep
                        // waiting for the slave's rlast rather than truncating.
                        err_d = (beat_q == len_q);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Channel routing: only the owner sees handshakes; the slave sees zeros when idle.
    always_comb begin
        araddr_s   = '0;
        arvalid_s  = 1'b0;
        arburst_s  = 2'b00;
        arlen_s    = 8'd0;
        arsize_s   = 3'd0;
        rready_s   = 1'b0;
        arready_m0 = 1'b0;
        arready_m1 = 1'b0;
        rvalid_m0  = 1'b0;
        rvalid_m1  = 1'b0;
        rlast_m0   = 1'b0;
        rlast_m1   = 1'b0;

        case (state_q)
            AR: begin
                araddr_s   = sel_araddr;
                arvalid_s  = sel_arvalid;
                arburst_s  = sel_arburst;
                arlen_s    = sel_arlen;
                arsize_s   = sel_arsize;
                arready_m0 = grant_q[0] && arready_s;
                arready_m1 = grant_q[1] && arready_s;
            end
            R: begin
                rready_s  = sel_rready;
                rvalid_m0 = grant_q[0] && rvalid_s;
                rvalid_m1 = grant_q[1] && rvalid_s;
                rlast_m0  = grant_q[0] && rlast_s;
                rlast_m1  = grant_q[1] && rlast_s;
            end
            default: ;
        endcase
    end

    // Data and response are broadcast; each master qualifies them with its rvalid.
    assign rdata_m0  = rdata_s;
    assign rdata_m1  = rdata_s;
    assign rresp_m0  = rresp_s;
    assign rresp_m1  = rresp_s;

    assign grant     = grant_q;
    assign burst_err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter. Two instances share every input: index 0 uses
// fixed priority, index 1 round-robin. A transaction-level model per instance
// predicts all outputs each cycle; directed tests pin key values by hand.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] araddr_m0, araddr_m1;
    logic        arvalid_m0, arvalid_m1, rready_m0, rready_m1;
    logic [1:0]  arburst_m0, arburst_m1;
    logic [7:0]  arlen_m0, arlen_m1;
    logic [2:0]  arsize_m0, arsize_m1;
    logic        arready_s, rvalid_s, rlast_s;
    logic [63:0] rdata_s;
    logic [1:0]  rresp_s;

    logic        arready_m0_o [2];
    logic        arready_m1_o [2];
    logic        rvalid_m0_o  [2];
    logic        rvalid_m1_o  [2];
    logic        rlast_m0_o   [2];
    logic        rlast_m1_o   [2];
    logic [63:0] rdata_m0_o   [2];
    logic [63:0] rdata_m1_o   [2];
    logic [1:0]  rresp_m0_o   [2];
    logic [1:0]  rresp_m1_o   [2];
    logic [31:0] araddr_s_o   [2];
    logic        arvalid_s_o  [2];
    logic [1:0]  arburst_s_o  [2];
    logic [7:0]  arlen_s_o    [2];
    logic [2:0]  arsize_s_o   [2];
    logic        rready_s_o   [2];
    logic [1:0]  grant_o      [2];
    logic        burst_err_o  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .PRIO_MODE(g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .araddr_m0  (araddr_m0),
            .arvalid_m0 (arvalid_m0),
            .arburst_m0 (arburst_m0),
            .arlen_m0   (arlen_m0),
            .arsize_m0  (arsize_m0),
            .rready_m0  (rready_m0),
            .arready_m0 (arready_m0_o[g]),
            .rvalid_m0  (rvalid_m0_o[g]),
            .rlast_m0   (rlast_m0_o[g]),
            .rdata_m0   (rdata_m0_o[g]),
            .rresp_m0   (rresp_m0_o[g]),
            .araddr_m1  (araddr_m1),
            .arvalid_m1 (arvalid_m1),
            .arburst_m1 (arburst_m1),
            .arlen_m1   (arlen_m1),
            .arsize_m1  (arsize_m1),
            .rready_m1  (rready_m1),
            .arready_m1 (arready_m1_o[g]),
            .rvalid_m1  (rvalid_m1_o[g]),
            .rlast_m1   (rlast_m1_o[g]),
            .rdata_m1   (rdata_m1_o[g]),
            .rresp_m1   (rresp_m1_o[g]),
            .araddr_s   (araddr_s_o[g]),
            .arvalid_s  (arvalid_s_o[g]),
            .arburst_s  (arburst_s_o[g]),
            .arlen_s    (arlen_s_o[g]),
            .arsize_s   (arsize_s_o[g]),
            .rready_s   (rready_s_o[g]),
            .arready_s  (arready_s),
            .rvalid_s   (rvalid_s),
            .rlast_s    (rlast_s),
            .rdata_s    (rdata_s),
            .rresp_s    (rresp_s),
            .grant      (grant_o[g]),
            .burst_err  (burst_err_o[g])
        );
    end

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 none, 0 icache, 1 dcache. addr_done: the AR handshake of the
    // current burst has happened. beats: beats accepted so far. last: last winner.
    int         m_owner [2];
    bit         m_addr  [2];
    logic [7:0] m_beats [2];
    logic [7:0] m_len   [2];
    int         m_last  [2];
    bit         m_err   [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic       own_v, own_rr;
            logic [7:0] own_len;
            own_v   = (m_owner[d] == 1) ? arvalid_m1 : arvalid_m0;
            own_rr  = (m_owner[d] == 1) ? rready_m1  : rready_m0;
            own_len = (m_owner[d] == 1) ? arlen_m1   : arlen_m0;
            if (rst) begin
                m_owner[d] = -1;
                m_addr[d]  = 1'b0;
                m_beats[d] = 8'd0;
                m_len[d]   = 8'd0;
                m_last[d]  = 0;
                m_err[d]   = 1'b0;
            end else begin
                m_err[d] = 1'b0;
                if (m_owner[d] < 0) begin
                    if (arvalid_m0 && arvalid_m1)
                        m_owner[d] = (d == 0) ? 1 : 1 - m_last[d];
                    else if (arvalid_m1)
                        m_owner[d] = 1;
                    else if (arvalid_m0)
                        m_owner[d] = 0;
                    m_addr[d] = 1'b0;
                end else if (!m_addr[d]) begin
                    if (own_v && arready_s) begin
                        m_addr[d]  = 1'b1;
                        m_len[d]   = own_len;
                        m_beats[d] = 8'd0;
                    end
                end else if (rvalid_s && own_rr) begin
                    // Beat number (0-based) is m_beats; the final one should be arlen.
                    if (rlast_s) begin
                        m_err[d]   = (m_beats[d] != m_len[d]);
                        m_last[d]  = m_owner[d];
                        m_owner[d] = -1;
                    end else begin
                        m_err[d] = (m_beats[d] == m_len[d]);
                    end
                    m_beats[d] = m_beats[d] + 8'd1;
                end
            end
        end
    end

    // Compare every DUT output against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                string p;
                bit    o1, in_ar, in_r;
                p     = $sformatf("u%0d ", d);
                o1    = (m_owner[d] == 1);
                in_ar = (m_owner[d] >= 0) && !m_addr[d];
                in_r  = (m_owner[d] >= 0) && m_addr[d];
                check({p, "grant"}, 80'(grant_o[d]),
                      80'((m_owner[d] == 0) ? 2'b01 : (m_owner[d] == 1) ? 2'b10 : 2'b00));
                check({p, "arvalid_s"}, 80'(arvalid_s_o[d]), 80'(in_ar && (o1 ? arvalid_m1 : arvalid_m0)));
                check({p, "araddr_s"},  80'(araddr_s_o[d]),  in_ar ? 80'(o1 ? araddr_m1 : araddr_m0) : 80'd0);
                check({p, "arburst_s"}, 80'(arburst_s_o[d]), in_ar ? 80'(o1 ? arburst_m1 : arburst_m0) : 80'd0);
                check({p, "arlen_s"},   80'(arlen_s_o[d]),   in_ar ? 80'(o1 ? arlen_m1 : arlen_m0) : 80'd0);
                check({p, "arsize_s"},  80'(arsize_s_o[d]),  in_ar ? 80'(o1 ? arsize_m1 : arsize_m0) : 80'd0);
                check({p, "arready_m0"}, 80'(arready_m0_o[d]), 80'(in_ar && !o1 && arready_s));
                check({p, "arready_m1"}, 80'(arready_m1_o[d]), 80'(in_ar &&  o1 && arready_s));
                check({p, "rready_s"},  80'(rready_s_o[d]),  80'(in_r && (o1 ? rready_m1 : rready_m0)));
                check({p, "rvalid_m0"}, 80'(rvalid_m0_o[d]), 80'(in_r && !o1 && rvalid_s));
                check({p, "rvalid_m1"}, 80'(rvalid_m1_o[d]), 80'(in_r &&  o1 && rvalid_s));
                check({p, "rlast_m0"},  80'(rlast_m0_o[d]),  80'(in_r && !o1 && rlast_s));
                check({p, "rlast_m1"},  80'(rlast_m1_o[d]),  80'(in_r &&  o1 && rlast_s));
                check({p, "rdata_m0"},  80'(rdata_m0_o[d]),  80'(rdata_s));
                check({p, "rdata_m1"},  80'(rdata_m1_o[d]),  80'(rdata_s));
                check({p, "rresp_m0"},  80'(rresp_m0_o[d]),  80'(rresp_s));
                check({p, "rresp_m1"},  80'(rresp_m1_o[d]),  80'(rresp_s));
                check({p, "burst_err"}, 80'(burst_err_o[d]), 80'(m_err[d]));
            end
        end
    end

    // ---------------- observation logs for the literal checks ----------------
    logic [1:0]  glog0 [$];
    logic [1:0]  glog1 [$];
    logic [64:0] q0 [$];            // {rlast, rdata} received by m0 on instance 0
    logic [64:0] q1 [$];            // same for m1
    logic [1:0]  prev_g0 = 2'b00;
    logic [1:0]  prev_g1 = 2'b00;
    int          errcnt0 = 0;
    int          errcnt1 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (grant_o[0] != 2'b00 && prev_g0 == 2'b00) glog0.push_back(grant_o[0]);
            if (grant_o[1] != 2'b00 && prev_g1 == 2'b00) glog1.push_back(grant_o[1]);
            prev_g0 = grant_o[0];
            prev_g1 = grant_o[1];
            if (burst_err_o[0]) errcnt0++;
            if (burst_err_o[1]) errcnt1++;
            if (rvalid_m0_o[0] && rready_m0) q0.push_back({rlast_m0_o[0], rdata_m0_o[0]});
            if (rvalid_m1_o[0] && rready_m1) q1.push_back({rlast_m1_o[0], rdata_m1_o[0]});
        end
    end

    function automatic logic [64:0] q0_at(input int i);
        return (i < q0.size()) ? q0[i] : 65'h1_ffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [64:0] q1_at(input int i);
        return (i < q1.size()) ? q1[i] : 65'h1_ffff_ffff_ffff_ffff;
    endfunction

    // ---------------- slave-side stimulus ----------------
    // Waits for the forwarded AR, stalls arready for 'stall' cycles, then handshakes.
    task automatic slave_ar(input int stall);
        int t;
        t = 0;
        #1;
        while (!arvalid_s_o[0] && t < 40) begin
            step();
            #1;
            t++;
        end
        check("ar request seen", 80'(arvalid_s_o[0]), 80'd1);
        repeat (stall) step();
        arready_s = 1'b1;
        step();
        arready_s = 1'b0;
    endtask

    // Offers n beats (data = base + inc*i, rresp cycling through all codes),
    // rlast on beat number last_beat (1-based), 'gap' idle cycles after each beat.
    task automatic slave_r(input int n, input int last_beat, input logic [63:0] base,
                           input logic [63:0] inc, input int gap);
        for (int i = 0; i < n; i++) begin
            int t;
            bit hs;
            rvalid_s = 1'b1;
            rdata_s  = base + inc * 64'(i);
            rresp_s  = 2'(i);
            rlast_s  = (i + 1 == last_beat);
            t  = 0;
            hs = 1'b0;
            while (!hs && t < 40) begin
                #2;
                hs = rready_s_o[0];
                step();
                t++;
            end
            check("beat accepted", 80'(hs), 80'd1);
            rvalid_s = 1'b0;
            rlast_s  = 1'b0;
            repeat (gap) step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, sg0, sg1, e0, e1;

        rst        = 1'b1;
        araddr_m0  = 32'h0;  araddr_m1  = 32'h0;
        arvalid_m0 = 1'b0;   arvalid_m1 = 1'b0;
        rready_m0  = 1'b1;   rready_m1  = 1'b1;
        arburst_m0 = 2'd1;   arburst_m1 = 2'd1;
        arlen_m0   = 8'd0;   arlen_m1   = 8'd0;
        arsize_m0  = 3'd3;   arsize_m1  = 3'd3;
        arready_s  = 1'b0;   rvalid_s   = 1'b0;
        rlast_s    = 1'b0;   rdata_s    = 64'h0;
        rresp_s    = 2'd0;

        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("reset grant u0", 80'(grant_o[0]), 80'd0);
        check("reset grant u1", 80'(grant_o[1]), 80'd0);
        check("reset burst_err", 80'(burst_err_o[0]), 80'd0);
        check("reset arvalid_s", 80'(arvalid_s_o[0]), 80'd0);

        // ---- m0 alone, 2-beat burst ----
        s0 = q0.size(); s1 = q1.size(); e0 = errcnt0;
        step();
        araddr_m0  = 32'h8000_0000;
        arlen_m0   = 8'd1;
        arvalid_m0 = 1'b1;
        #1;
        check("idle cycle grant", 80'(grant_o[0]), 80'd0);
        check("idle cycle arvalid_s", 80'(arvalid_s_o[0]), 80'd0);
        step();
        #1;
        check("t1 grant", 80'(grant_o[0]), 80'h1);
        check("t1 araddr_s", 80'(araddr_s_o[0]), 80'h8000_0000);
        slave_ar(0);
        arvalid_m0 = 1'b0;
        slave_r(2, 2, 64'h11, 64'h11, 0);
        step();
        check("t1 m0 beat1", 80'(q0_at(s0)),     80'h0_0000_0000_0000_0011);
        check("t1 m0 beat2", 80'(q0_at(s0 + 1)), 80'h1_0000_0000_0000_0022);
        check("t1 m0 beat count", 80'(q0.size() - s0), 80'd2);
        check("t1 m1 untouched", 80'(q1.size() - s1), 80'd0);
        check("t1 no burst_err", 80'(errcnt0 - e0), 80'd0);

        // ---- simultaneous requests, fixed priority: m1 then m0 ----
        s0 = q0.size(); s1 = q1.size(); sg0 = glog0.size();
        araddr_m0 = 32'h8000_0040; arlen_m0 = 8'd0;
        araddr_m1 = 32'h4000_1000; arlen_m1 = 8'd1;
        arvalid_m0 = 1'b1;
        arvalid_m1 = 1'b1;
        slave_ar(0);
        arvalid_m1 = 1'b0;
        slave_r(2, 2, 64'hA1, 64'h1, 0);
        slave_ar(0);
        arvalid_m0 = 1'b0;
        slave_r(1, 1, 64'hB1, 64'h1, 0);
        step();
        check("t2 first grant",  80'((glog0.size() > sg0)     ? glog0[sg0]     : 2'b11), 80'h2);
        check("t2 second grant", 80'((glog0.size() > sg0 + 1) ? glog0[sg0 + 1] : 2'b11), 80'h1);
        check("t2 m1 beat1", 80'(q1_at(s1)),     80'h0_0000_0000_0000_00A1);
        check("t2 m1 beat2", 80'(q1_at(s1 + 1)), 80'h1_0000_0000_0000_00A2);
        check("t2 m0 beat",  80'(q0_at(s0)),     80'h1_0000_0000_0000_00B1);
        check("t2 m0 count", 80'(q0.size() - s0), 80'd1);

        // ---- both request continuously for 4 single-beat bursts ----
        sg0 = glog0.size(); sg1 = glog1.size();
        arvalid_m0 = 1'b1;
        arvalid_m1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            slave_ar(0);
            if (i == 3) begin
                arvalid_m0 = 1'b0;
                arvalid_m1 = 1'b0;
            end
            slave_r(1, 1, 64'h100 + 64'(i), 64'h1, 0);
        end
        step();
        check("rr grant seq", 80'((glog1.size() >= sg1 + 4) ?
              {glog1[sg1], glog1[sg1 + 1], glog1[sg1 + 2], glog1[sg1 + 3]} : 8'h00), 80'b10_01_10_01);
        check("fixed grant seq", 80'((glog0.size() >= sg0 + 4) ?
              {glog0[sg0], glog0[sg0 + 1], glog0[sg0 + 2], glog0[sg0 + 3]} : 8'h00), 80'b10_10_10_10);

        // ---- slave stalls: arready late, rvalid gaps, rready_m0 low 2 cycles ----
        s0 = q0.size();
        araddr_m0 = 32'h8000_0100; arlen_m0 = 8'd3;
        arvalid_m0 = 1'b1;
        slave_ar(5);
        arvalid_m0 = 1'b0;
        fork
            slave_r(4, 4, 64'hC0, 64'h1, 1);
            begin
                step();
                rready_m0 = 1'b0;
                step();
                step();
                rready_m0 = 1'b1;
            end
        join
        step();
        check("stall count", 80'(q0.size() - s0), 80'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("stall beat%0d", i), 80'(q0_at(s0 + i)),
                  {15'd0, (i == 3), 64'hC0 + 64'(i)});

        // ---- arlen 3, rlast early on beat 2: one error pulse ----
        e0 = errcnt0; e1 = errcnt1;
        arvalid_m0 = 1'b1;
        slave_ar(0);
        arvalid_m0 = 1'b0;
        slave_r(2, 2, 64'hD0, 64'h1, 0);
        repeat (2) step();
        check("early rlast err u0", 80'(errcnt0 - e0), 80'd1);
        check("early rlast err u1", 80'(errcnt1 - e1), 80'd1);
        check("early rlast idle", 80'(grant_o[0]), 80'd0);

        // ---- arlen 3, rlast late on beat 5: pulse at beat 4, and again at
        //      the rlast beat whose count no longer matches ----
        s0 = q0.size(); e0 = errcnt0;
        arvalid_m0 = 1'b1;
        slave_ar(0);
        arvalid_m0 = 1'b0;
        slave_r(4, 0, 64'hE0, 64'h1, 0);
        step();
        check("late rlast err at beat4", 80'(errcnt0 - e0), 80'd1);
        slave_r(1, 1, 64'hE4, 64'h1, 0);
        repeat (2) step();
        check("late rlast err total", 80'(errcnt0 - e0), 80'd2);
        check("late rlast not truncated", 80'(q0.size() - s0), 80'd5);

        // ---- reset during beat 1 of a 4-beat burst ----
        arvalid_m0 = 1'b1;
        slave_ar(0);
        arvalid_m0 = 1'b0;
        rvalid_s = 1'b1;
        rdata_s  = 64'hF0;
        rst      = 1'b1;
        step();
        #1;
        check("rst grant u0", 80'(grant_o[0]), 80'd0);
        check("rst grant u1", 80'(grant_o[1]), 80'd0);
        check("rst arvalid_s", 80'(arvalid_s_o[0]), 80'd0);
        check("rst rready_s", 80'(rready_s_o[0]), 80'd0);
        check("rst rvalid_m0", 80'(rvalid_m0_o[0]), 80'd0);
        rst      = 1'b0;
        rvalid_s = 1'b0;

        s1 = q1.size(); sg0 = glog0.size();
        araddr_m1 = 32'h4000_2000; arlen_m1 = 8'd0;
        arvalid_m1 = 1'b1;
        slave_ar(0);
        arvalid_m1 = 1'b0;
        slave_r(1, 1, 64'h5A, 64'h1, 0);
        repeat (2) step();
        check("post-rst grant", 80'((glog0.size() > sg0) ? glog0[sg0] : 2'b11), 80'h2);
        check("post-rst beat", 80'(q1_at(s1)), 80'h1_0000_0000_0000_005A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
